// File: rtl/reset_seq_gen.sv
// rtl/reset_seq_gen.sv - staggered active-low reset release generator
//
// Purpose: holds every rst_n_out line low for STRETCH_CYC cycles after a reset
// event, then releases the lines one at a time (bit 0 first) GAP_CYC cycles
// apart. Re-arms on a synchronised external request.
//
// Ports:
//   clk        in   1        single clock, all logic on posedge
//   reset      in   1        synchronous active-high block reset
//   rst_req    in   1        asynchronous external reset request, active-high
//   rst_n_out  out  NUM_OUT  generated active-low resets, bit 0 released first
//   busy       out  1        1 while any rst_n_out bit is 0
//   rel_done   out  1        one-cycle pulse on the edge releasing the last bit
//
// Configuration macro: RST_REQ_DEBOUNCE_EN
//   defined   : a request fires only after DEB_CYC consecutive synced-high cycles
//               (level-sensitive while held)
//   undefined : any single synced-high cycle fires a request; DEB_CYC is ignored

module reset_seq_gen #(
  parameter int NUM_OUT     = 3,
  parameter int STRETCH_CYC = 16,
  parameter int GAP_CYC     = 4,
  parameter int DEB_CYC     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rst_req,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               busy,
  output logic               rel_done
);

  localparam int MAX_SG = (STRETCH_CYC > GAP_CYC) ? STRETCH_CYC : GAP_CYC;
  localparam int MAX_C  = (MAX_SG > DEB_CYC) ? MAX_SG : DEB_CYC;
  localparam int CW     = $clog2(MAX_C) + 1;
  localparam int IW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] HOLD_TC  = CW'(STRETCH_CYC - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OUT - 1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] STAGGER = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] idx;
  logic          sync1;
  logic          sync2;
  logic          req_s;
  logic          fire;
  logic          first_cyc;

  // Two-flop synchroniser for the asynchronous request.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= rst_req;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;

`ifdef RST_REQ_DEBOUNCE_EN
  localparam logic [CW-1:0] DEB_TC = CW'(DEB_CYC);

  logic [CW-1:0] deb_cnt;

  // Counts consecutive synced-high cycles and parks at DEB_CYC, so a held
  // request keeps firing every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
    end else if (!req_s) begin
      deb_cnt <= '0;
    end else if (deb_cnt != DEB_TC) begin
      deb_cnt <= deb_cnt + CW'(1);
    end
  end

  assign fire = (deb_cnt == DEB_TC);
`else
  logic fire_q;

  // Registered so the FSM reacts one edge after req_s is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= req_s;
    end
  end

  assign fire = fire_q;
`endif

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  assign busy = ~(&rst_n_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      rel_done  <= 1'b0;
      first_cyc <= 1'b1;
    end else begin
      rel_done  <= 1'b0;
      first_cyc <= 1'b0;
      case (state)
        HOLD: begin
          if (fire) begin
            cnt <= '0;
          end else if (first_cyc) begin
            // The first edge after reset drops does not advance the stretch,
            // so bit 0 is released STRETCH_CYC edges after reset is sampled low.
            cnt <= '0;
          end else if (cnt == HOLD_TC) begin
            rst_n_out[0] <= 1'b1;
            cnt          <= '0;
            if (NUM_OUT == 1) begin
              state    <= RUN;
              rel_done <= 1'b1;
            end else begin
              idx   <= IW'(1);
              state <= STAGGER;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        STAGGER: begin
          if (fire) begin
            // No partial release: everything drops and the stretch restarts.
            rst_n_out <= '0;
            cnt       <= '0;
            idx       <= '0;
            state     <= HOLD;
          end else if (cnt == GAP_TC) begin
            rst_n_out[idx] <= 1'b1;
            cnt            <= '0;
            if (idx == IDX_LAST) begin
              state    <= RUN;
              rel_done <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        RUN: begin
          if (fire) begin
            rst_n_out <= '0;
            cnt       <= '0;
            idx       <= '0;
            state     <= HOLD;
          end
        end
        default: begin
          rst_n_out <= '0;
          cnt       <= '0;
          idx       <= '0;
          state     <= HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_seq_gen.sv
// tb/tb_reset_seq_gen.sv - directed self-checking bench for reset_seq_gen

module tb_reset_seq_gen;

  logic       clk;
  logic       reset;
  logic       rst_req;
  logic [2:0] rst_n_out;
  logic       busy;
  logic       rel_done;

  int total;
  int bad;

`ifdef RST_REQ_DEBOUNCE_EN
  localparam int LAT  = 6;
  localparam int HOLD = 4;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
`endif
  localparam int IN_RUN = 1000;

  reset_seq_gen #(
    .NUM_OUT    (3),
    .STRETCH_CYC(16),
    .GAP_CYC    (4),
    .DEB_CYC    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rst_req  (rst_req),
    .rst_n_out(rst_n_out),
    .busy     (busy),
    .rel_done (rel_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {rst_n_out, busy, rel_done} n edges after a reset/request event.
  function automatic logic [4:0] exp_vec(input int n);
    logic [2:0] o;
    for (int k = 0; k < 3; k++) o[k] = (n >= 16 + 4 * k);
    return {o, (n < 24), (n == 24)};
  endfunction

  task automatic test_reset();
    reset   = 1'b1;
    rst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({rst_n_out, busy, rel_done} !== 5'b000_1_0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {rst_n_out, busy, rel_done}, 5'b000_1_0);
      end
    end
    reset = 1'b0;
    for (int m = 0; m <= 26; m++) begin
      tick();
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(m)) begin
        bad++;
        $display("FAIL reset_release E0+%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(m));
      end
    end
  endtask

  task automatic test_run_request();
    int a;
    int f;
    int n;
    a = 1;
    f = a + 1 + LAT;
    for (int m = 1; m <= f + 26; m++) begin
      tick();
      n = (m < f) ? IN_RUN : m - f;
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(n)) begin
        bad++;
        $display("FAIL run_request m=%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(n));
      end
      rst_req = (m >= a && m < a + HOLD);
    end
  endtask

  task automatic test_hold_restart();
    int a1;
    int f1;
    int a2;
    int f2;
    int n;
    a1 = 1;
    f1 = a1 + 1 + LAT;
    a2 = f1 + 9;
    f2 = a2 + 1 + LAT;
    for (int m = 1; m <= f2 + 26; m++) begin
      tick();
      n = (m < f1) ? IN_RUN : (m < f2) ? m - f1 : m - f2;
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(n)) begin
        bad++;
        $display("FAIL hold_restart m=%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(n));
      end
      rst_req = (m >= a1 && m < a1 + HOLD) || (m >= a2 && m < a2 + HOLD);
    end
  endtask

  task automatic test_stagger_abort();
    int a1;
    int f1;
    int a2;
    int f2;
    int n;
    a1 = 1;
    f1 = a1 + 1 + LAT;
    f2 = f1 + 19;
    a2 = f2 - 1 - LAT;
    for (int m = 1; m <= f2 + 26; m++) begin
      tick();
      n = (m < f1) ? IN_RUN : (m < f2) ? m - f1 : m - f2;
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(n)) begin
        bad++;
        $display("FAIL stagger_abort m=%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(n));
      end
      rst_req = (m >= a1 && m < a1 + HOLD) || (m >= a2 && m < a2 + HOLD);
    end
  endtask

  task automatic test_reset_dominates();
    // From RUN: reset with a simultaneous request.
    reset   = 1'b1;
    rst_req = 1'b1;
    tick();
    total++;
    if ({rst_n_out, busy, rel_done} !== 5'b000_1_0) begin
      bad++;
      $display("FAIL reset_in_run got=%b want=%b", {rst_n_out, busy, rel_done}, 5'b000_1_0);
    end
    rst_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int m = 0; m <= 17; m++) begin
      tick();
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(m)) begin
        bad++;
        $display("FAIL reset_run_release E0+%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(m));
      end
    end
    // Now in STAGGER with bit 0 released.
    reset   = 1'b1;
    rst_req = 1'b1;
    tick();
    total++;
    if ({rst_n_out, busy, rel_done} !== 5'b000_1_0) begin
      bad++;
      $display("FAIL reset_in_stagger got=%b want=%b", {rst_n_out, busy, rel_done}, 5'b000_1_0);
    end
    rst_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    for (int m = 0; m <= 26; m++) begin
      tick();
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(m)) begin
        bad++;
        $display("FAIL reset_stagger_release E0+%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(m));
      end
    end
  endtask

`ifdef RST_REQ_DEBOUNCE_EN
  task automatic test_debounce_short();
    for (int m = 1; m <= 15; m++) begin
      tick();
      total++;
      if ({rst_n_out, busy, rel_done} !== exp_vec(IN_RUN)) begin
        bad++;
        $display("FAIL debounce_short m=%0d got=%b want=%b", m, {rst_n_out, busy, rel_done}, exp_vec(IN_RUN));
      end
      rst_req = (m >= 1 && m < 4);
    end
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    rst_req = 1'b0;
    test_reset();
    test_run_request();
    test_hold_restart();
    test_stagger_abort();
    test_reset_dominates();
`ifdef RST_REQ_DEBOUNCE_EN
    test_debounce_short();
    test_run_request();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
